// File: rtl/fp_scale_sequencer_if.sv
// ---------------------------------------------------------------------------
// fp_scale_sequencer_if
//   Sample streaming bus for fp_scale_sequencer: an input stream and an output
//   stream of complex IEEE-754 single-precision samples.
//
//   Handshake (both streams): a beat moves on a rising clock edge where
//   valid && ready are both high. The producer holds valid and its data
//   stable until that edge. The consumer may drive ready regardless of
//   valid. out_last marks the final beat of a frame and is meaningful only
//   while out_valid is high.
//
//   Signals
//     in_valid / in_ready        input stream handshake
//     in_re / in_im   [31:0]     input real / imaginary part
//     out_valid / out_ready      output stream handshake
//     out_re / out_im [31:0]     scaled real / imaginary part
//     out_last                   last sample of the frame
//
//   Modports
//     slave  : the scaler (consumes the input stream, produces the output)
//     master : the environment around it
// ---------------------------------------------------------------------------
interface fp_scale_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_re;
  logic [31:0] in_im;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_re;
  logic [31:0] out_im;
  logic        out_last;

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last
  );

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last
  );
endinterface

// File: rtl/fp_scale_sequencer.sv
// ---------------------------------------------------------------------------
// fp_scale_sequencer
//   Frame-sequenced power-of-two scaler for complex single-precision samples
//   sitting between FFT stages. Each frame of FRAME_LEN samples is divided by
//   2^k by subtracting k from the exponent field; k is captured once when the
//   frame starts. Zero/denormal inputs flush to signed zero, Inf/NaN pass
//   unchanged, and exponents that would reach zero or below flush to signed
//   zero and are counted as underflows.
//
//   Ports
//     clk          clock, rising edge
//     rst_n        asynchronous active-low reset
//     i_start      frame start request, honoured only while idle
//     i_cfg_shift  shift amount k, captured on an accepted start
//     o_busy       frame in progress (RUN or DRAIN)
//     o_done       one-cycle pulse after the frame's last sample has left
//     o_uflow_cnt  underflowed components in the current/last frame (saturating)
//     o_state      FSM state for observation (0 IDLE, 1 RUN, 2 DRAIN)
//     s_if         sample streams (see fp_scale_sequencer_if)
//
//   Parameters
//     FRAME_LEN    complex samples per frame
//     CNT_W        sample counter width, 2^CNT_W >= FRAME_LEN
// ---------------------------------------------------------------------------
module fp_scale_sequencer #(
  parameter int FRAME_LEN = 625,
  parameter int CNT_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [7:0]            i_cfg_shift,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [15:0]           o_uflow_cnt,
  output logic [1:0]            o_state,
  fp_scale_sequencer_if.slave   s_if
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [7:0]       r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_uflow;
  logic             r_done;
  logic             r_out_valid;
  logic             r_out_last;
  logic [31:0]      r_out_re;
  logic [31:0]      r_out_im;

  logic             w_in_ready;
  logic             w_busy;
  logic             w_accept_start;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_last_in;
  logic             w_frame_end;
  logic [32:0]      w_re_res;
  logic [32:0]      w_im_res;
  logic [16:0]      w_uflow_sum;
  logic [15:0]      w_uflow_next;

  // Returns {underflow_flag, scaled_value} for one component.
  function automatic logic [32:0] scale_comp(input logic [31:0] x,
                                             input logic [7:0]  k);
    logic [7:0] e;
    e = x[30:23];
    if (e == 8'd0)
      scale_comp = {1'b0, x[31], 31'd0};
    else if (e == 8'hFF)
      scale_comp = {1'b0, x};
    else if (e <= k)
      scale_comp = {1'b1, x[31], 31'd0};
    else
      scale_comp = {1'b0, x[31], e - k, x[22:0]};
  endfunction

  // Handshake decodes.
  assign w_in_xfer   = s_if.in_valid && w_in_ready;
  assign w_out_xfer  = r_out_valid && s_if.out_ready;
  assign w_last_in   = w_in_xfer && (r_cnt == CNT_W'(FRAME_LEN - 1));
  assign w_frame_end = (r_state == S_DRAIN) && w_out_xfer && r_out_last;

  assign w_re_res = scale_comp(s_if.in_re, r_shift);
  assign w_im_res = scale_comp(s_if.in_im, r_shift);

  // Both components can underflow in one beat; one extra bit catches the
  // overflow so the count can pin at all-ones.
  assign w_uflow_sum  = {1'b0, r_uflow} + 17'(w_re_res[32]) + 17'(w_im_res[32]);
  assign w_uflow_next = w_uflow_sum[16] ? 16'hFFFF : w_uflow_sum[15:0];

  // FSM next state and state-derived outputs.
  always_comb begin
    w_next_state   = r_state;
    w_in_ready     = 1'b0;
    w_busy         = 1'b0;
    w_accept_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept_start = 1'b1;
          w_next_state   = S_RUN;
        end
      end
      S_RUN: begin
        w_busy     = 1'b1;
        // A sample may enter when the output slot is empty or draining now.
        w_in_ready = !r_out_valid || s_if.out_ready;
        if (w_last_in)
          w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_frame_end)
          w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  // Frame bookkeeping: captured shift, sample counter, underflow count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= 8'd0;
      r_cnt   <= '0;
      r_uflow <= 16'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      if (w_accept_start) begin
        r_shift <= i_cfg_shift;
        r_cnt   <= '0;
        r_uflow <= 16'd0;
      end else if (w_in_xfer) begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_uflow <= w_uflow_next;
      end
    end
  end

  // Single output register stage. A simultaneous in/out transfer keeps the
  // slot full with the new sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_re    <= 32'd0;
      r_out_im    <= 32'd0;
    end else begin
      if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        r_out_last  <= w_last_in;
        r_out_re    <= w_re_res[31:0];
        r_out_im    <= w_im_res[31:0];
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign s_if.in_ready  = w_in_ready;
  assign s_if.out_valid = r_out_valid;
  assign s_if.out_last  = r_out_last;
  assign s_if.out_re    = r_out_re;
  assign s_if.out_im    = r_out_im;

  assign o_busy      = w_busy;
  assign o_done      = r_done;
  assign o_uflow_cnt = r_uflow;
  assign o_state     = r_state;

endmodule
